// File: rtl/fir_decim_requant.sv
// fir_decim_requant: keeps one of every D valid FIR results, rounds half-up,
// shifts, saturates to OW bits and buffers the result in a small FWFT FIFO
// with a valid/ready output. The input side never stalls; words that find the
// FIFO full are dropped and flagged.
module fir_decim_requant #(
  parameter int IW    = 31,
  parameter int OW    = 16,
  parameter int SHIFT = 11,
  parameter int DECW  = 5,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic [DECW-1:0] i_dec,
  input  logic            i_valid,
  input  logic [IW-1:0]   i_sample,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [OW-1:0]   o_sample,
  output logic            o_sat,
  output logic            o_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic signed [IW:0] HALF = (IW+1)'(1) << (SHIFT-1);
  localparam logic signed [IW:0] QMAX = (IW+1)'((1 << (OW-1)) - 1);
  localparam logic signed [IW:0] QMIN = ~QMAX;

  logic [DECW-1:0]      phase;
  logic [DECW-1:0]      phase_load;
  logic                 keep;

  logic signed [IW:0]   r1;
  logic                 v1;

  logic signed [IW:0]   q;
  logic [OW-1:0]        s2_data;
  logic                 s2_clip;

  logic [OW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        rd_next;
  logic [AW:0]          count;
  logic [AW:0]          count_next;
  logic [OW-1:0]        head_next;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 drop;

  // A zero decimation factor behaves like 1, so the reload value is 0 either way.
  assign phase_load = (i_dec == '0) ? '0 : i_dec - DECW'(1);
  assign keep       = i_valid && (phase == '0);

  // Phase counter: reload on a kept sample, count down on every other valid one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase <= '0;
    end else if (i_clear) begin
      phase <= '0;
    end else if (i_valid) begin
      phase <= keep ? phase_load : phase - DECW'(1);
    end
  end

  // Stage 1: sign-extend by one bit and add half an LSB of the output scale.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= keep;
      if (keep) begin
        r1 <= {i_sample[IW-1], i_sample} + HALF;
      end
    end
  end

  assign q = r1 >>> SHIFT;

  // Stage 2: clip the shifted value into the signed OW-bit range.
  always_comb begin
    s2_data = q[OW-1:0];
    s2_clip = 1'b0;
    if (q > QMAX) begin
      s2_data = QMAX[OW-1:0];
      s2_clip = 1'b1;
    end else if (q < QMIN) begin
      s2_data = QMIN[OW-1:0];
      s2_clip = 1'b1;
    end
  end

  assign pop     = o_valid && i_ready;
  assign full    = (count == FULL_COUNT);
  assign wr_en   = v1 && (!full || pop);
  assign drop    = v1 && full && !pop;
  assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

  // Next occupancy and next head word; a word written into the new head slot bypasses the array.
  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
    head_next = mem[rd_next];
    if (wr_en && (wr_ptr == rd_next)) begin
      head_next = s2_data;
    end
  end

  // FIFO storage, pointers and registered head/valid outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_valid  <= 1'b0;
      o_sample <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= s2_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_next;
      count   <= count_next;
      o_valid <= (count_next != '0);
      if (count_next != '0) begin
        o_sample <= head_next;
      end
    end
  end

  // Sticky status flags; a new event in the same cycle as a clear wins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_sat      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (v1 && s2_clip) begin
        o_sat <= 1'b1;
      end else if (i_clear) begin
        o_sat <= 1'b0;
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clear) begin
        o_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench for fir_decim_requant: rounding table, saturation, decimation,
// backpressure/overflow, simultaneous pop+write on a full FIFO, async reset.
module tb_fir_decim_requant;

  localparam int IW    = 31;
  localparam int OW    = 16;
  localparam int DECW  = 5;
  localparam int NVEC  = 8;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_clear;
  logic [DECW-1:0] i_dec;
  logic            i_valid;
  logic [IW-1:0]   i_sample;
  logic            o_valid;
  logic            i_ready;
  logic [OW-1:0]   o_sample;
  logic            o_sat;
  logic            o_overflow;

  int checks = 0;
  int errors = 0;
  int got_q[$];

  typedef struct {
    int sample;
    int exp_out;
    int exp_sat;
  } vec_t;

  vec_t vecs[NVEC];

  fir_decim_requant dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (i_clear),
    .i_dec      (i_dec),
    .i_valid    (i_valid),
    .i_sample   (i_sample),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sample   (o_sample),
    .o_sat      (o_sat),
    .o_overflow (o_overflow)
  );

  // Free-running clock, period 10.
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int s);
    i_valid  = v;
    i_sample = s[IW-1:0];
  endtask

  // Advance to the next falling edge and record any word the DUT will pop at the next rise.
  task automatic cycle();
    @(negedge i_clk);
    if (o_valid && i_ready) got_q.push_back(int'($signed(o_sample)));
  endtask

  task automatic pulseClear();
    i_clear = 1'b1;
    cycle();
    i_clear = 1'b0;
    cycle();
  endtask

  task automatic checkQueue(input string name, input int exp[$]);
    checkOutput({name, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checkOutput($sformatf("%s[%0d]", name, i), (i < got_q.size()) ? got_q[i] : -999999, exp[i]);
    end
  endtask

  task automatic runDecimation(input bit toggle, input bit change);
    got_q.delete();
    for (int k = 1; k <= 9; k++) begin
      cycle();
      if (change && k == 5) i_dec = 5'd2;
      applyStimulus(1'b1, k * 2048);
      if (toggle) begin
        cycle();
        applyStimulus(1'b0, 0);
      end
    end
    cycle();
    applyStimulus(1'b0, 0);
    repeat (5) cycle();
  endtask

  initial begin
    vecs[0] = '{10240, 5, 0};
    vecs[1] = '{1023, 0, 0};
    vecs[2] = '{1024, 1, 0};
    vecs[3] = '{-1024, 0, 0};
    vecs[4] = '{-1025, -1, 0};
    vecs[5] = '{-2048, -1, 0};
    vecs[6] = '{1073741823, 32767, 1};
    vecs[7] = '{-1073741824, -32768, 1};

    i_reset_n = 1'b0;
    i_clear   = 1'b0;
    i_dec     = 5'd1;
    i_ready   = 1'b1;
    applyStimulus(1'b0, 0);

    repeat (3) cycle();
    checkOutput("reset_o_valid", int'(o_valid), 0);
    checkOutput("reset_o_sample", int'($signed(o_sample)), 0);
    checkOutput("reset_o_sat", int'(o_sat), 0);
    checkOutput("reset_o_overflow", int'(o_overflow), 0);
    i_reset_n = 1'b1;
    cycle();

    // Rounding and saturation stream, D=1, each output two cycles after its input.
    for (int i = 0; i < NVEC + 2; i++) begin
      cycle();
      if (i >= 2) begin
        checkOutput($sformatf("round_valid[%0d]", i-2), int'(o_valid), 1);
        checkOutput($sformatf("round_out[%0d]", i-2), int'($signed(o_sample)), vecs[i-2].exp_out);
        checkOutput($sformatf("round_sat[%0d]", i-2), int'(o_sat), vecs[i-2].exp_sat);
      end
      if (i < NVEC) applyStimulus(1'b1, vecs[i].sample);
      else          applyStimulus(1'b0, 0);
    end
    repeat (3) cycle();
    checkOutput("sat_sticky", int'(o_sat), 1);
    checkOutput("stream_drained", int'(o_valid), 0);
    pulseClear();
    checkOutput("sat_cleared", int'(o_sat), 0);

    // Decimation by 3: back-to-back, gapped, and with a mid-period factor change.
    i_dec = 5'd3;
    pulseClear();
    runDecimation(1'b0, 1'b0);
    checkQueue("dec3_b2b", '{1, 4, 7});
    i_dec = 5'd3;
    pulseClear();
    runDecimation(1'b1, 1'b0);
    checkQueue("dec3_toggle", '{1, 4, 7});
    i_dec = 5'd3;
    pulseClear();
    runDecimation(1'b0, 1'b1);
    checkQueue("dec_change", '{1, 4, 7, 9});

    // Backpressure: six words into a four-deep FIFO.
    i_dec   = 5'd1;
    i_ready = 1'b0;
    pulseClear();
    for (int k = 1; k <= 6; k++) begin
      cycle();
      applyStimulus(1'b1, k * 2048);
    end
    cycle();
    applyStimulus(1'b0, 0);
    repeat (3) cycle();
    checkOutput("ovf_o_valid", int'(o_valid), 1);
    checkOutput("ovf_flag", int'(o_overflow), 1);
    checkOutput("ovf_head", int'($signed(o_sample)), 1);
    i_ready = 1'b1;
    for (int j = 2; j <= 4; j++) begin
      cycle();
      checkOutput($sformatf("ovf_drain[%0d]", j), int'($signed(o_sample)), j);
      checkOutput($sformatf("ovf_drain_valid[%0d]", j), int'(o_valid), 1);
    end
    cycle();
    checkOutput("ovf_empty", int'(o_valid), 0);
    pulseClear();
    checkOutput("ovf_cleared", int'(o_overflow), 0);

    // Full FIFO with a pop in the same cycle that word 5 reaches the write port.
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i < 5) applyStimulus(1'b1, (i + 1) * 2048);
      else       applyStimulus(1'b0, 0);
    end
    checkOutput("full_head", int'($signed(o_sample)), 1);
    i_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      cycle();
      checkOutput($sformatf("full_drain[%0d]", j), int'($signed(o_sample)), j);
    end
    cycle();
    checkOutput("full_empty", int'(o_valid), 0);
    checkOutput("full_no_overflow", int'(o_overflow), 0);

    // Async reset mid-stream with two words queued and a nonzero phase.
    i_ready = 1'b0;
    i_dec   = 5'd3;
    pulseClear();
    for (int k = 1; k <= 4; k++) begin
      cycle();
      applyStimulus(1'b1, k * 2048);
    end
    cycle();
    applyStimulus(1'b0, 0);
    repeat (3) cycle();
    checkOutput("prerst_o_valid", int'(o_valid), 1);
    checkOutput("prerst_head", int'($signed(o_sample)), 1);
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput("rst_async_o_valid", int'(o_valid), 0);
    checkOutput("rst_async_o_sample", int'($signed(o_sample)), 0);
    cycle();
    i_reset_n = 1'b1;
    i_ready   = 1'b1;
    cycle();
    applyStimulus(1'b1, 7 * 2048);
    cycle();
    applyStimulus(1'b0, 0);
    cycle();
    checkOutput("postrst_valid", int'(o_valid), 1);
    checkOutput("postrst_out", int'($signed(o_sample)), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
